// File: rtl/cacheline_burst_adaptor_pkg.sv
// cacheline_burst_adaptor_pkg: FSM encodings and geometry helpers for the line/burst bridge
package cacheline_burst_adaptor_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  function automatic int beats_of(input int line_width, input int burst_width);
    return line_width / burst_width;
  endfunction
  function automatic int offset_of(input int line_width);
    return $clog2(line_width / 8);
  endfunction
endpackage

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: bridges full-line LLC requests to BEATS-beat memory bursts
module cacheline_burst_adaptor
  import cacheline_burst_adaptor_pkg::*;
#(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);
  localparam int BEATS  = beats_of(LINE_WIDTH, BURST_WIDTH);
  localparam int OFFSET = offset_of(LINE_WIDTH);
  localparam int CW     = $clog2(BEATS);
  if (LINE_WIDTH % BURST_WIDTH != 0 || BEATS < 2) begin : g_bad_geometry
    $error("LINE_WIDTH must be a multiple of BURST_WIDTH with at least two beats");
  end
  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [LINE_WIDTH-1:0] line_buf;
  logic [LINE_WIDTH-1:0] next_buf;
  logic [ADDR_WIDTH-1:0] aligned;
  logic                  last;
  // line buffer serves both read assembly and write data; only one transfer is ever in flight
  always_comb begin
    next_buf = line_buf;
    next_buf[cnt*BURST_WIDTH +: BURST_WIDTH] = burst_i;
  end
  assign aligned = {address_i[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
  assign last    = cnt == CW'(BEATS - 1);
  assign read_o  = state == READ;
  assign write_o = state == WRITE;
  assign resp_o  = state == DONE;
  assign burst_o = write_o ? line_buf[cnt*BURST_WIDTH +: BURST_WIDTH] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      line_buf  <= '0;
      line_o    <= '0;
      address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            address_o <= aligned;
            line_buf  <= line_i;
            state     <= WRITE;
          end else if (read_i) begin
            address_o <= aligned;
            state     <= READ;
          end
        end
        READ: begin
          if (resp_i) begin
            line_buf <= next_buf;
            cnt      <= last ? '0 : cnt + CW'(1);
            if (last) begin
              line_o <= next_buf;
              state  <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            cnt <= last ? '0 : cnt + CW'(1);
            if (last) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
